// File: rtl/gpio_in_filter.sv
// -----------------------------------------------------------------------------
// gpio_in_filter
//
// Input conditioning between the GPIO pads and the GPIO core. Each pad is
// first brought into the PCLK domain through a SYNC_STAGES-deep flop chain,
// then passed through a per-pin glitch/debounce filter. A new level is
// accepted only after th+1 consecutive PCLK edges on which the synchronised
// level differs from the filtered level. Any edge on which they agree
// restarts the count. th = 0 degenerates to a plain one-register delay.
//
// Registered rise/fall pulses appear in the same cycle pin_filt shows the
// new level, so the core can set its interrupt flags directly from them.
//
// Ports:
//   PCLK        system clock, all flops on the rising edge
//   PRESET      asynchronous active-high reset, clears every flop
//   pin_async   raw pad inputs, asynchronous to PCLK
//   filt_th     per-pin thresholds, pin i uses [i*TH_W +: TH_W]
//   pin_filt    filtered, synchronous pin level
//   rise_pulse  one-cycle pulse on a filtered 0->1 transition
//   fall_pulse  one-cycle pulse on a filtered 1->0 transition
//
// SYNC_STAGES must be 2 or more for metastability protection.
// -----------------------------------------------------------------------------
module gpio_in_filter #(
    parameter int WIDTH       = 32,
    parameter int TH_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [WIDTH-1:0]        pin_async,
    input  logic [WIDTH*TH_W-1:0]   filt_th,
    output logic [WIDTH-1:0]        pin_filt,
    output logic [WIDTH-1:0]        rise_pulse,
    output logic [WIDTH-1:0]        fall_pulse
);

    // Synchroniser chain; index is the stage, the last stage feeds the filter.
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [TH_W-1:0]  cnt_q  [WIDTH];

    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] mism;
    logic [WIDTH-1:0] accept;

    function automatic logic [TH_W-1:0] th_of(input logic [WIDTH*TH_W-1:0] th_vec,
                                              input int pin);
        th_of = th_vec[pin*TH_W +: TH_W];
    endfunction

    assign sync_lvl = sync_p[SYNC_STAGES-1];

    // cnt counts mismatching edges already seen; once it has reached th the
    // current mismatching edge is the (th+1)-th and the new level is taken.
    // Comparing with >= also covers th being lowered below a running count.
    always_comb begin
        mism   = '0;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mism[i]   = sync_lvl[i] ^ pin_filt[i];
            accept[i] = mism[i] && (cnt_q[i] >= th_of(filt_th, i));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            pin_filt   <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            // --- stage: synchroniser ---
            sync_p[0] <= pin_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end

            // --- stage: filter and edge pulses ---
            pin_filt   <= pin_filt ^ accept;
            rise_pulse <= accept & sync_lvl;
            fall_pulse <= accept & ~sync_lvl;
            for (int i = 0; i < WIDTH; i++) begin
                if (!mism[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

endmodule
